// File: rtl/dmem_arb_pkg.sv
// Shared types and default constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0]  BE_FULL         = 4'hF;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'h1001_0000;
  localparam int          DEF_DEPTH_WORDS = 2048;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted port.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q;
  logic last_d;

  // last_q = 1 means port 1 was granted last, so port 0 is favoured next.
  always_comb begin
    grant = req;
    if (req[0] && req[1]) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
    last_d = last_q;
    if (advance && (grant != 2'b00)) begin
      last_d = grant[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the CPU (port 0) and the debug/loader
// port (port 1); byte-enable stores narrower than a word use read-modify-write.
// Handshake: rN_req is held until rN_ack, a one-cycle pulse qualified by rN_err.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [3:0]  r0_be,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_ack,
  output logic        r0_err,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [3:0]  r1_be,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_ack,
  output logic        r1_err,
  output logic [31:0] r1_rdata,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH_WORDS);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [29:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        port_q, port_d;
  logic        err_q, err_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic [1:0]  grant;
  logic        advance;
  logic [31:0] byte_addr;
  logic [31:0] offset;
  logic        in_range;
  logic [31:0] merged;

  assign advance = (state_q == ST_IDLE);

  rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({r1_req, r0_req}),
    .advance (advance),
    .grant   (grant)
  );

  // Unsigned wrap makes addresses below the base land far outside the window.
  assign byte_addr = {waddr_q, 2'b00};
  assign offset    = byte_addr - BASE_ADDR;
  assign in_range  = (offset < WIN_BYTES);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      merged[8*k +: 8] = be_q[k] ? wdata_q[8*k +: 8] : merge_q[8*k +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    be_d      = be_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    port_d    = port_q;
    err_d     = err_q;
    merge_d   = merge_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    mem_write = 1'b0;
    mem_wdata = 32'h0;
    r0_ack    = 1'b0;
    r1_ack    = 1'b0;
    r0_err    = 1'b0;
    r1_err    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          port_d  = grant[1];
          err_d   = 1'b0;
          state_d = ST_ACCESS;
          if (grant[1]) begin
            we_d    = r1_we;
            be_d    = r1_be;
            waddr_d = r1_addr[31:2];
            wdata_d = r1_wdata;
          end else begin
            we_d    = r0_we;
            be_d    = r0_be;
            waddr_d = r0_addr[31:2];
            wdata_d = r0_wdata;
          end
        end
      end

      ST_ACCESS: begin
        state_d = ST_DONE;
        if (!in_range) begin
          err_d = 1'b1;
        end else if (!we_q) begin
          if (port_q) begin
            rdata1_d = mem_rdata;
          end else begin
            rdata0_d = mem_rdata;
          end
        end else if (be_q == BE_FULL) begin
          mem_write = 1'b1;
          mem_wdata = wdata_q;
        end else if (be_q != 4'h0) begin
          merge_d = mem_rdata;
          state_d = ST_MERGE;
        end
      end

      ST_MERGE: begin
        mem_write = 1'b1;
        mem_wdata = merged;
        state_d   = ST_DONE;
      end

      ST_DONE: begin
        r0_ack  = !port_q;
        r1_ack  = port_q;
        r0_err  = !port_q && err_q;
        r1_err  = port_q && err_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      be_q     <= 4'h0;
      waddr_q  <= 30'h0;
      wdata_q  <= 32'h0;
      port_q   <= 1'b0;
      err_q    <= 1'b0;
      merge_q  <= 32'h0;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      be_q     <= be_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      port_q   <= port_d;
      err_q    <= err_d;
      merge_q  <= merge_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign mem_addr  = byte_addr;
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory and an ack scoreboard.
module tb_dmem_arbiter;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [3:0]  r0_be = 0, r1_be = 0;
  logic [31:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
  logic        r0_ack, r0_err, r1_ack, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  logic [31:0] mem [0:2047];
  logic [31:0] moff;
  logic        bd_we = 0;
  logic [10:0] bd_idx = 0;
  logic [31:0] bd_val = 0;

  // {port, check_rdata, err, rdata}
  logic [34:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_be(r0_be), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_be(r1_be), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Memory: combinational read, write committed on the falling edge.
  assign moff      = mem_addr - BASE;
  assign mem_rdata = mem[moff[12:2]];

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'h0;
    end else begin
      if (mem_write) mem[moff[12:2]] <= mem_wdata;
      if (bd_we) mem[bd_idx] <= bd_val;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one expected completion.
  always @(negedge clk) begin
    logic [34:0] e;
    if (!rst) begin
      if (mem_write) wr_cnt++;
      if (r0_ack && r1_ack) begin
        check("dual_ack", 32'd1, 32'd0);
      end else if (r0_ack || r1_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack_port", {31'h0, r1_ack}, {31'h0, e[34]});
          check("ack_err", {31'h0, r1_ack ? r1_err : r0_err}, {31'h0, e[32]});
          if (e[33]) check("ack_rdata", r1_ack ? r1_rdata : r0_rdata, e[31:0]);
        end
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] val);
    bd_idx = idx[10:0];
    bd_val = val;
    bd_we  = 1'b1;
    @(negedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic drive_req(input int p, input logic req, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wd);
    if (p == 0) begin
      r0_req = req; r0_we = we; r0_be = be; r0_addr = addr; r0_wdata = wd;
    end else begin
      r1_req = req; r1_we = we; r1_be = be; r1_addr = addr; r1_wdata = wd;
    end
  endtask

  // Issues one transaction from an idle cycle and checks its ack latency.
  task automatic run_one(input int p, input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wd, input logic err, input logic [31:0] rd,
                         input int lat);
    int n = 0;
    logic got = 1'b0;
    logic pb = (p != 0);
    exp_q.push_back({pb, ~we & ~err, err, rd});
    drive_req(p, 1'b1, we, be, addr, wd);
    while (!got && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      got = (p == 0) ? r0_ack : r1_ack;
    end
    check("latency", n, lat);
    drive_req(p, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  task automatic port_loop(input int p, input logic [31:0] addr, output int k);
    int n = 0;
    k = 0;
    drive_req(p, 1'b1, 1'b0, 4'h0, addr, 32'h0);
    while (k < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if ((p == 0) ? r0_ack : r1_ack) k++;
    end
    drive_req(p, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int k0, k1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_r0_ack", {31'h0, r0_ack}, 32'h0);
    check("rst_r1_ack", {31'h0, r1_ack}, 32'h0);
    check("rst_r0_rdata", r0_rdata, 32'h0);
    check("rst_r1_rdata", r1_rdata, 32'h0);
    check("rst_mem_write", {31'h0, mem_write}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);

    // Load after reset
    poke(1, 32'hDEADBEEF);
    run_one(0, 1'b0, 4'h0, 32'h1001_0004, 32'h0, 1'b0, 32'hDEADBEEF, 2);
    check("r1_rdata_untouched", r1_rdata, 32'h0);

    // Full store then reload
    w0 = wr_cnt;
    run_one(1, 1'b1, 4'hF, 32'h1001_0010, 32'h12345678, 1'b0, 32'h0, 2);
    check("full_store_writes", wr_cnt - w0, 1);
    run_one(0, 1'b0, 4'h0, 32'h1001_0010, 32'h0, 1'b0, 32'h12345678, 2);

    // Partial stores (read-modify-write)
    poke(8, 32'hAABBCCDD);
    w0 = wr_cnt;
    run_one(0, 1'b1, 4'b0010, 32'h1001_0020, 32'h00001100, 1'b0, 32'h0, 3);
    check("partial_store_writes", wr_cnt - w0, 1);
    run_one(0, 1'b0, 4'h0, 32'h1001_0020, 32'h0, 1'b0, 32'hAABB11DD, 2);
    poke(9, 32'h11223344);
    run_one(1, 1'b1, 4'b1001, 32'h1001_0024, 32'hAA0000BB, 1'b0, 32'h0, 3);
    run_one(1, 1'b0, 4'h0, 32'h1001_0024, 32'h0, 1'b0, 32'hAA2233BB, 2);

    // Zero byte-enable store leaves memory alone
    w0 = wr_cnt;
    run_one(0, 1'b1, 4'h0, 32'h1001_0010, 32'hFFFFFFFF, 1'b0, 32'h0, 2);
    check("zero_be_writes", wr_cnt - w0, 0);
    run_one(0, 1'b0, 4'h0, 32'h1001_0010, 32'h0, 1'b0, 32'h12345678, 2);

    // Window edges and ignored low address bits
    poke(2047, 32'hCAFEF00D);
    run_one(1, 1'b0, 4'h0, 32'h1001_1FFC, 32'h0, 1'b0, 32'hCAFEF00D, 2);
    run_one(0, 1'b0, 4'h0, 32'h1001_0007, 32'h0, 1'b0, 32'hDEADBEEF, 2);
    w0 = wr_cnt;
    run_one(0, 1'b1, 4'hF, 32'h1000_FFFC, 32'h55555555, 1'b1, 32'h0, 2);
    run_one(0, 1'b0, 4'h0, 32'h1001_2000, 32'h0, 1'b1, 32'h0, 2);
    run_one(1, 1'b1, 4'b0001, 32'h1001_2000, 32'h00000077, 1'b1, 32'h0, 2);
    check("oow_writes", wr_cnt - w0, 0);
    check("oow_mem_top", mem[2047], 32'hCAFEF00D);
    check("oow_mem_zero", mem[0], 32'h0);
    check("oow_r0_rdata_held", r0_rdata, 32'hDEADBEEF);

    // Reset during MERGE of a port-0 partial store
    poke(3, 32'h01020304);
    drive_req(0, 1'b1, 1'b1, 4'b0100, 32'h1001_000C, 32'h00FF0000);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_state", {30'h0, dbg_state}, 32'd2);
    check("pre_rst_mem_write", {31'h0, mem_write}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_state", {30'h0, dbg_state}, 32'h0);
    check("mid_rst_ack", {31'h0, r0_ack}, 32'h0);
    check("mid_rst_mem_write", {31'h0, mem_write}, 32'h0);
    drive_req(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_r0_rdata", r0_rdata, 32'h0);

    // Contention: both ports request continuously; grants alternate from port 0
    poke(16, 32'hA0A0A0A0);
    poke(17, 32'hB1B1B1B1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, 1'b1, 1'b0, 32'hA0A0A0A0});
      exp_q.push_back({1'b1, 1'b1, 1'b0, 32'hB1B1B1B1});
    end
    fork
      port_loop(0, 32'h1001_0040, k0);
      port_loop(1, 32'h1001_0044, k1);
    join
    check("cont_acks0", k0, 3);
    check("cont_acks1", k1, 3);

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single-port data memory between two requesters: port 0 is the CPU load/store stage, port 1 is the debug/loader port.
- Handles round-robin selection, address-window checking and byte-enable stores; partial stores use read-modify-write.
- Sits directly in front of the memory. It drives the memory write strobe, address and write data, and consumes the memory's combinational read data.
- The memory commits writes on the falling edge of clk.

## Interface
Parameters:
- BASE_ADDR, 32'h10010000, byte address of memory word 0
- DEPTH_WORDS, 2048, memory depth in 32-bit words; valid window is BASE_ADDR .. BASE_ADDR+4*DEPTH_WORDS-1

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- rN_req  in  1  request valid (N = 0,1); held high until rN_ack
- rN_we  in  1  1 = store, 0 = load
- rN_be  in  4  byte enables for stores, bit k = byte lane k (bits 8k+7:8k); ignored for loads
- rN_addr  in  32  byte address; bits [1:0] ignored
- rN_wdata  in  32  store data, lane-aligned
- rN_ack  out  1  one-cycle completion pulse
- rN_err  out  1  valid with rN_ack; address outside window
- rN_rdata  out  32  load data, registered, held until the next load ack to that port
- mem_write  out  1  memory write strobe
- mem_addr  out  32  byte address to memory
- mem_wdata  out  32  write data to memory
- mem_rdata  in  32  combinational read data from memory

## Operation
States: IDLE, ACCESS, MERGE, DONE.
- **IDLE**
  - If any req is high, select a requester and go to ACCESS.
  - Latch we, be, addr, wdata and the selected port into internal registers.
- **ACCESS** (mem_addr = latched addr)
  - Address out of window: no memory write, err flag set, go to DONE.
  - Load: capture mem_rdata into the port's rdata register at the exit edge, go to DONE.
  - Store with be == 4'hF: mem_write = 1 for this cycle, mem_wdata = latched wdata, go to DONE.
  - Store with be == 4'h0: no write, go to DONE.
  - Other store: capture mem_rdata into a merge register, go to MERGE.
- **MERGE**
  - mem_write = 1.
  - mem_wdata = per-lane select: latched wdata where be is set, merge register otherwise.
  - Go to DONE.
- **DONE**
  - Assert ack (and err if flagged) for the granted port only.
  - Go to IDLE.

Arbitration:
- Round-robin with a last-grant pointer. If both ports request, the port not granted last wins.
- After reset, port 0 wins.
- Only one transaction is in flight. A request arriving mid-transaction waits in IDLE.

Window check:
- In range when (addr - BASE_ADDR) < 4*DEPTH_WORDS.
- The subtraction is 32-bit unsigned, so addresses below BASE wrap large and fail.

## Timing
- Request sampled at edge E (IDLE→ACCESS).
- Load, full store, zero-be store, error: ack high in the cycle after E+1, i.e. 2 cycles after sampling.
- Partial store: ack 3 cycles after sampling.
- mem_write is high for exactly one full clock cycle: ACCESS for full stores, MERGE for partial stores. The memory commits at that cycle's falling edge, so the write is visible to a read in the following cycle.
- rN_rdata updates at the same edge that raises rN_ack.
- A requester holding req through its ack cycle issues a new transaction. Round-robin still gives the other port priority if it is requesting.

Reset (asynchronous):
- Forces IDLE and port-0 priority.
- All of the following go to 0: ack, err, rdata, mem_write, mem_addr, mem_wdata and the latched registers.
- Reset mid-transaction abandons the transaction with no ack. Memory contents are cleared by the memory's own reset.

## Structure
- **Package dmem_arb_pkg:** state enum (IDLE/ACCESS/MERGE/DONE), BE_FULL = 4'hF, default BASE_ADDR and DEPTH_WORDS constants.
- **Sub-module rr_arb2:** 2-way round-robin with last-grant pointer. Inputs req[1:0] and an advance strobe; output one-hot grant. Instantiated once.
- Lane merge stays inline in dmem_arbiter.

## Test plan
- **Load after reset:** memory word at 0x10010004 = 0xDEADBEEF; r0 load 0x10010004 → r0_ack 2 cycles later, r0_rdata = 0xDEADBEEF, r0_err = 0, r1_ack never pulses.
- **Full store:** r1 store 0x10010010, be = F, data 0x12345678 → mem_write high one cycle, r1_ack after 2 cycles; a subsequent r0 load of the same address returns 0x12345678.
- **Partial store:** word = 0xAABBCCDD; r0 store be = 4'b0010, data 0x00001100 → ack after 3 cycles; reload returns 0xAABB11DD.
- **Contention:** r0 and r1 both request continuously → grants alternate 0,1,0,1; no port acked twice in a row; exactly one ack per transaction.
- **Out-of-window:** r0 store to 0x1000FFFC and load 0x10012000 → ack with r0_err = 1; mem_write never asserted; memory unchanged.
- **Reset mid-transaction:** rst asserted during MERGE → immediately IDLE, no ack, mem_write low; post-reset r0/r1 simultaneous request grants port 0 first.
